data_mem_ctrl: RTL

Single-port data memory with a request/acknowledge handshake. It sits directly downstream of the `merge_execution` stage. It consumes that stage's `dmem_req/addr/we/wdata` outputs and returns `dmem_rdata` and `dmem_ack`. Each transaction is serviced with a programmable number of wait states, so the execution stage's LOAD/STORE path sees a realistic multi-cycle memory instead of a combinational array.

---
 rtl/simple_processor_pkg.sv | 7 +
 rtl/data_mem_ctrl.sv | 130 +++++++++++++
 2 files changed

// File: rtl/simple_processor_pkg.sv
// Shared widths for the simple processor datapath.
// Pure parameter package, no logic.
// Consumed by the execution stage and the data memory controller.
package simple_processor_pkg;
    parameter int ADDR_WIDTH = 32;
    parameter int DATA_WIDTH = 32;
endpackage

// File: rtl/data_mem_ctrl.sv
// Purpose: single-port data memory behind a req/ack handshake, WAIT_CYCLES programmable wait states.
// Latency: ack is seen WAIT_CYCLES+1 edges after the request is first sampled; one transaction per WAIT_CYCLES+2 cycles.
// Backpressure: none queued; requests seen outside IDLE are dropped, so the requester must hold req until ack.
// Optional feature: define DMEM_BOUNDS_CHECK_EN to flag (and suppress) accesses beyond DEPTH words.
module data_mem_ctrl #(
    parameter int ADDR_WIDTH  = simple_processor_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH  = simple_processor_pkg::DATA_WIDTH,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  dmem_req_i,
    input  logic [ADDR_WIDTH-1:0] dmem_addr_i,
    input  logic                  dmem_we_i,
    input  logic [DATA_WIDTH-1:0] dmem_wdata_i,
    output logic [DATA_WIDTH-1:0] dmem_rdata_o,
    output logic                  dmem_ack_o,
    output logic                  dmem_err_o
);

    localparam int IDX_W = $clog2(DEPTH);
    // Counter preload; only meaningful when WAIT_CYCLES > 0.
    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]            state;
    logic [3:0]            wait_cnt;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic                  lat_we;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] sel_addr;
    logic                  sel_we;
    logic [IDX_W-1:0]      sel_idx;
    logic                  sel_oor;
    logic                  enter_resp;

    // With zero wait states RESP is entered straight from IDLE, before the
    // latches hold the request, so the live inputs are used in that case.
    always_comb begin
        sel_addr   = lat_addr;
        sel_we     = lat_we;
        enter_resp = 1'b0;
        case (state)
            ST_IDLE: begin
                sel_addr   = dmem_addr_i;
                sel_we     = dmem_we_i;
                enter_resp = dmem_req_i && (WAIT_CYCLES == 0);
            end
            ST_BUSY: enter_resp = (wait_cnt == 4'd0);
            default: enter_resp = 1'b0;
        endcase
    end

    assign sel_idx = sel_addr[IDX_W-1:0];

`ifdef DMEM_BOUNDS_CHECK_EN
    assign sel_oor = (sel_addr >> IDX_W) != '0;

    // Error flag accompanies the ack of an out-of-range access.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dmem_err_o <= 1'b0;
        end else begin
            dmem_err_o <= enter_resp && sel_oor;
        end
    end
`else
    // Upper address bits are ignored; addresses alias modulo DEPTH.
    logic unused_addr_bits;
    assign unused_addr_bits = ^sel_addr;
    assign sel_oor          = 1'b0;
    assign dmem_err_o       = 1'b0;
`endif

    // Handshake FSM: capture in IDLE, count wait states in BUSY, ack in RESP.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= ST_IDLE;
            wait_cnt   <= 4'd0;
            lat_addr   <= '0;
            lat_we     <= 1'b0;
            lat_wdata  <= '0;
            dmem_ack_o <= 1'b0;
        end else begin
            dmem_ack_o <= enter_resp;
            case (state)
                ST_IDLE: begin
                    if (dmem_req_i) begin
                        lat_addr  <= dmem_addr_i;
                        lat_we    <= dmem_we_i;
                        lat_wdata <= dmem_wdata_i;
                        wait_cnt  <= WAIT_INIT;
                        state     <= (WAIT_CYCLES == 0) ? ST_RESP : ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (wait_cnt == 4'd0) begin
                        state <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Read data is loaded only on RESP entry and held otherwise; stores return 0.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dmem_rdata_o <= '0;
        end else if (enter_resp) begin
            dmem_rdata_o <= (sel_we || sel_oor) ? '0 : mem[sel_idx];
        end
    end

    // Store commits on the edge leaving RESP; reset on that edge cancels it.
    always_ff @(posedge clk_i) begin
        if (!rst_i && state == ST_RESP && lat_we && !sel_oor) begin
            mem[sel_idx] <= lat_wdata;
        end
    end

endmodule
